// File: rtl/multicycle_control_fsm.sv
// ============================================================================
//  Module   : multicycle_control_fsm
//  Purpose  : Main control state machine for the multicycle MIPS datapath.
//             Decodes the registered instruction word and drives every
//             datapath control line each cycle, handles the memory-ready
//             handshake, pulses instr_done on the last cycle of each
//             instruction and keeps a sticky illegal-instruction flag.
//  Ports    : clock, reset_n (sync, active-low)
//             instr[31:0], zero, mem_ready              - inputs
//             pc_write, iord, ir_write, mem_write,
//             mem_to_reg[1:0], reg_dst[1:0], reg_write,
//             alu_src_a, alu_src_b[1:0], alu_control,
//             pc_src[1:0]                               - datapath controls
//             instr_done, illegal, state                - status / debug
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control_fsm #(
    parameter int ALU_W   = 5,
    parameter int STATE_W = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [31:0]        instr,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               iord,
    output logic               ir_write,
    output logic               mem_write,
    output logic [1:0]         mem_to_reg,
    output logic [1:0]         reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALU_W-1:0]   alu_control,
    output logic [1:0]         pc_src,
    output logic               instr_done,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [4:0] ALU_ADD  = 5'b00010;
    localparam logic [4:0] ALU_SUB  = 5'b00110;
    localparam logic [4:0] ALU_AND  = 5'b00000;
    localparam logic [4:0] ALU_OR   = 5'b00001;
    localparam logic [4:0] ALU_SLT  = 5'b00111;

    state_t     cur_state;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       opcode_ok;
    logic       funct_ok;
    logic [4:0] alu_op;
    logic       pc_write_raw;
    logic       ir_write_raw;
    logic       mem_write_raw;
    logic       reg_write_raw;
    logic       done_raw;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign state  = STATE_W'(cur_state);

    // Supported opcodes; R-type is accepted here and its funct is checked in EXEC.
    always_comb begin
        opcode_ok = 1'b0;
        case (opcode)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ,
            OP_ADDI, OP_LW, OP_SW: opcode_ok = 1'b1;
            default:               opcode_ok = 1'b0;
        endcase
    end

    // R-type ALU function decode; JR never reaches EXEC so it is not listed.
    always_comb begin
        funct_ok = 1'b1;
        alu_op   = ALU_ADD;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
    end

    // State register and sticky illegal flag.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cur_state <= S_FETCH;
            illegal   <= 1'b0;
        end else begin
            case (cur_state)
                S_FETCH:  if (mem_ready) cur_state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: cur_state <= S_MEMADR;
                        OP_RTYPE:     cur_state <= (funct == FN_JR) ? S_JR : S_EXEC;
                        OP_BEQ:       cur_state <= S_BRANCH;
                        OP_ADDI:      cur_state <= S_ADDIEX;
                        OP_J:         cur_state <= S_JUMP;
                        OP_JAL:       cur_state <= S_JAL;
                        default: begin
                            illegal   <= 1'b1;
                            cur_state <= S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: cur_state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (mem_ready) cur_state <= S_MEMWB;
                S_MEMWB:  cur_state <= S_FETCH;
                S_MEMWR:  if (mem_ready) cur_state <= S_FETCH;
                S_EXEC: begin
                    if (!funct_ok) begin
                        illegal   <= 1'b1;
                        cur_state <= S_FETCH;
                    end else begin
                        cur_state <= S_ALUWB;
                    end
                end
                S_ALUWB:  cur_state <= S_FETCH;
                S_BRANCH: cur_state <= S_FETCH;
                S_ADDIEX: cur_state <= S_ADDIWB;
                S_ADDIWB: cur_state <= S_FETCH;
                S_JUMP:   cur_state <= S_FETCH;
                S_JAL:    cur_state <= S_FETCH;
                S_JR:     cur_state <= S_FETCH;
                default:  cur_state <= S_FETCH;
            endcase
        end
    end

    // Control decode from the state register; mem_ready and zero are the only
    // combinational inputs besides the instruction fields.
    always_comb begin
        pc_write_raw  = 1'b0;
        iord          = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        mem_to_reg    = 2'b00;
        reg_dst       = 2'b00;
        reg_write_raw = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_control   = ALU_W'(ALU_ADD);
        pc_src        = 2'b00;
        done_raw      = 1'b0;
        case (cur_state)
            S_FETCH: begin
                alu_src_b    = 2'b01;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                done_raw  = ~opcode_ok;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD:  iord = 1'b1;
            S_MEMWB: begin
                mem_to_reg    = 2'b01;
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            S_MEMWR: begin
                iord          = 1'b1;
                mem_write_raw = 1'b1;
                done_raw      = mem_ready;
            end
            S_EXEC: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_W'(alu_op);
                done_raw    = ~funct_ok;
            end
            S_ALUWB: begin
                reg_dst       = 2'b01;
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a    = 1'b1;
                alu_control  = ALU_W'(ALU_SUB);
                pc_src       = 2'b01;
                pc_write_raw = zero;
                done_raw     = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            S_JUMP: begin
                pc_src       = 2'b10;
                pc_write_raw = 1'b1;
                done_raw     = 1'b1;
            end
            S_JAL: begin
                // Writes the already-incremented PC (PC+4) into $31.
                reg_dst       = 2'b10;
                mem_to_reg    = 2'b10;
                reg_write_raw = 1'b1;
                pc_src        = 2'b10;
                pc_write_raw  = 1'b1;
                done_raw      = 1'b1;
            end
            S_JR: begin
                pc_src       = 2'b11;
                pc_write_raw = 1'b1;
                done_raw     = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset overrides every write strobe immediately, even mid-instruction.
    assign pc_write   = reset_n & pc_write_raw;
    assign ir_write   = reset_n & ir_write_raw;
    assign mem_write  = reset_n & mem_write_raw;
    assign reg_write  = reset_n & reg_write_raw;
    assign instr_done = reset_n & done_raw;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
// ============================================================================
//  Module   : tb_multicycle_control_fsm
//  Purpose  : Self-checking bench for multicycle_control_fsm. A per-cycle
//             table of inputs and hand-computed outputs, followed by
//             instruction-latency sequences with memory stalls.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control_fsm;

    logic        clock;
    logic        reset_n;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        pc_write;
    logic        iord;
    logic        ir_write;
    logic        mem_write;
    logic [1:0]  mem_to_reg;
    logic [1:0]  reg_dst;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [4:0]  alu_control;
    logic [1:0]  pc_src;
    logic        instr_done;
    logic        illegal;
    logic [3:0]  state;

    multicycle_control_fsm #(.ALU_W(5), .STATE_W(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .instr       (instr),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .iord        (iord),
        .ir_write    (ir_write),
        .mem_write   (mem_write),
        .mem_to_reg  (mem_to_reg),
        .reg_dst     (reg_dst),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .pc_src      (pc_src),
        .instr_done  (instr_done),
        .illegal     (illegal),
        .state       (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [31:0] I_LW   = 32'h8D280004;
    localparam logic [31:0] I_SW   = 32'hAD280004;
    localparam logic [31:0] I_ADD  = 32'h01095020;
    localparam logic [31:0] I_SUB  = 32'h01095022;
    localparam logic [31:0] I_OR   = 32'h01095025;
    localparam logic [31:0] I_SLT  = 32'h0109502A;
    localparam logic [31:0] I_BADF = 32'h01095021;
    localparam logic [31:0] I_ADDI = 32'h21280005;
    localparam logic [31:0] I_BEQ  = 32'h11090003;
    localparam logic [31:0] I_J    = 32'h08000100;
    localparam logic [31:0] I_JAL  = 32'h0C000100;
    localparam logic [31:0] I_JR   = 32'h03E00008;
    localparam logic [31:0] I_BAD  = 32'hFC000000;

    localparam logic [4:0] A_ADD = 5'b00010;
    localparam logic [4:0] A_SUB = 5'b00110;
    localparam logic [4:0] A_OR  = 5'b00001;
    localparam logic [4:0] A_SLT = 5'b00111;

    // exp = {state, pc_write, iord, ir_write, mem_write, mem_to_reg, reg_dst,
    //        reg_write, alu_src_a, alu_src_b, alu_control, pc_src, instr_done, illegal}
    typedef struct {
        logic        rst_n;
        logic [31:0] ins;
        logic        z;
        logic        mr;
        logic [24:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   errors;

    function automatic void row(
        input logic r, input logic [31:0] ins, input logic z, input logic mr,
        input logic [3:0] st, input logic pcw, input logic io, input logic irw,
        input logic mw, input logic [1:0] m2r, input logic [1:0] rd,
        input logic rw, input logic asa, input logic [1:0] asb,
        input logic [4:0] alu, input logic [1:0] pcs, input logic dn, input logic il);
        vec_t v;
        v.rst_n = r;
        v.ins   = ins;
        v.z     = z;
        v.mr    = mr;
        v.exp   = {st, pcw, io, irw, mw, m2r, rd, rw, asa, asb, alu, pcs, dn, il};
        vecs.push_back(v);
    endfunction

    function automatic logic [24:0] actual();
        return {state, pc_write, iord, ir_write, mem_write, mem_to_reg, reg_dst,
                reg_write, alu_src_a, alu_src_b, alu_control, pc_src, instr_done, illegal};
    endfunction

    // Counts cycles from FETCH up to and including the instr_done cycle, with
    // mem_ready low for the first 'stalls' cycles (all spent in FETCH).
    task automatic run_lat(input logic [31:0] ins, input int stalls,
                           input int exp_cyc, input string name);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clock);
            reset_n   = 1'b1;
            instr     = ins;
            zero      = 1'b1;
            mem_ready = (k < stalls) ? 1'b0 : 1'b1;
            #2;
            cyc++;
            if (instr_done) seen = 1'b1;
        end
        checks++;
        if (!seen || cyc != exp_cyc) begin
            errors++;
            $display("FAIL latency %s: got %0d cycles (done seen=%0d), required %0d",
                     name, cyc, seen, exp_cyc);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        instr     = 32'h0;
        zero      = 1'b0;
        mem_ready = 1'b1;

        //   r  instr   z mr  st pcw io irw mw m2r rd rw asa asb alu    pcs dn il
        // reset held for a second edge: strobes forced off
        row(0, I_LW,   0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, A_ADD, 0, 0, 0);
        // lw, no stalls
        row(1, I_LW,   0, 1,  0, 1, 0, 1, 0, 0, 0, 0, 0, 1, A_ADD, 0, 0, 0);
        row(1, I_LW,   0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 3, A_ADD, 0, 0, 0);
        row(1, I_LW,   0, 1,  2, 0, 0, 0, 0, 0, 0, 0, 1, 2, A_ADD, 0, 0, 0);
        row(1, I_LW,   0, 1,  3, 0, 1, 0, 0, 0, 0, 0, 0, 0, A_ADD, 0, 0, 0);
        row(1, I_LW,   0, 1,  4, 0, 0, 0, 0, 1, 0, 1, 0, 0, A_ADD, 0, 1, 0);
        // lw with three MEMRD stall cycles
        row(1, I_LW,   0, 1,  0, 1, 0, 1, 0, 0, 0, 0, 0, 1, A_ADD, 0, 0, 0);
        row(1, I_LW,   0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 3, A_ADD, 0, 0, 0);
        row(1, I_LW,   0, 1,  2, 0, 0, 0, 0, 0, 0, 0, 1, 2, A_ADD, 0, 0, 0);
        row(1, I_LW,   0, 0,  3, 0, 1, 0, 0, 0, 0, 0, 0, 0, A_ADD, 0, 0, 0);
        row(1, I_LW,   0, 0,  3, 0, 1, 0, 0, 0, 0, 0, 0, 0, A_ADD, 0, 0, 0);
        row(1, I_LW,   0, 0,  3, 0, 1, 0, 0, 0, 0, 0, 0, 0, A_ADD, 0, 0, 0);
        row(1, I_LW,   0, 1,  3, 0, 1, 0, 0, 0, 0, 0, 0, 0, A_ADD, 0, 0, 0);
        row(1, I_LW,   0, 1,  4, 0, 0, 0, 0, 1, 0, 1, 0, 0, A_ADD, 0, 1, 0);
        // add with one FETCH stall
        row(1, I_ADD,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, A_ADD, 0, 0, 0);
        row(1, I_ADD,  0, 1,  0, 1, 0, 1, 0, 0, 0, 0, 0, 1, A_ADD, 0, 0, 0);
        row(1, I_ADD,  0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 3, A_ADD, 0, 0, 0);
        row(1, I_ADD,  0, 1,  6, 0, 0, 0, 0, 0, 0, 0, 1, 0, A_ADD, 0, 0, 0);
        row(1, I_ADD,  0, 1,  7, 0, 0, 0, 0, 0, 1, 1, 0, 0, A_ADD, 0, 1, 0);
        // slt, sub, or
        row(1, I_SLT,  0, 1,  0, 1, 0, 1, 0, 0, 0, 0, 0, 1, A_ADD, 0, 0, 0);
        row(1, I_SLT,  0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 3, A_ADD, 0, 0, 0);
        row(1, I_SLT,  0, 1,  6, 0, 0, 0, 0, 0, 0, 0, 1, 0, A_SLT, 0, 0, 0);
        row(1, I_SLT,  0, 1,  7, 0, 0, 0, 0, 0, 1, 1, 0, 0, A_ADD, 0, 1, 0);
        row(1, I_SUB,  0, 1,  0, 1, 0, 1, 0, 0, 0, 0, 0, 1, A_ADD, 0, 0, 0);
        row(1, I_SUB,  0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 3, A_ADD, 0, 0, 0);
        row(1, I_SUB,  0, 1,  6, 0, 0, 0, 0, 0, 0, 0, 1, 0, A_SUB, 0, 0, 0);
        row(1, I_SUB,  0, 1,  7, 0, 0, 0, 0, 0, 1, 1, 0, 0, A_ADD, 0, 1, 0);
        row(1, I_OR,   0, 1,  0, 1, 0, 1, 0, 0, 0, 0, 0, 1, A_ADD, 0, 0, 0);
        row(1, I_OR,   0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 3, A_ADD, 0, 0, 0);
        row(1, I_OR,   0, 1,  6, 0, 0, 0, 0, 0, 0, 0, 1, 0, A_OR,  0, 0, 0);
        row(1, I_OR,   0, 1,  7, 0, 0, 0, 0, 0, 1, 1, 0, 0, A_ADD, 0, 1, 0);
        // sw with one MEMWR stall
        row(1, I_SW,   0, 1,  0, 1, 0, 1, 0, 0, 0, 0, 0, 1, A_ADD, 0, 0, 0);
        row(1, I_SW,   0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 3, A_ADD, 0, 0, 0);
        row(1, I_SW,   0, 1,  2, 0, 0, 0, 0, 0, 0, 0, 1, 2, A_ADD, 0, 0, 0);
        row(1, I_SW,   0, 0,  5, 0, 1, 0, 1, 0, 0, 0, 0, 0, A_ADD, 0, 0, 0);
        row(1, I_SW,   0, 1,  5, 0, 1, 0, 1, 0, 0, 0, 0, 0, A_ADD, 0, 1, 0);
        // addi
        row(1, I_ADDI, 0, 1,  0, 1, 0, 1, 0, 0, 0, 0, 0, 1, A_ADD, 0, 0, 0);
        row(1, I_ADDI, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 3, A_ADD, 0, 0, 0);
        row(1, I_ADDI, 0, 1,  9, 0, 0, 0, 0, 0, 0, 0, 1, 2, A_ADD, 0, 0, 0);
        row(1, I_ADDI, 0, 1, 10, 0, 0, 0, 0, 0, 0, 1, 0, 0, A_ADD, 0, 1, 0);
        // beq taken, then not taken
        row(1, I_BEQ,  1, 1,  0, 1, 0, 1, 0, 0, 0, 0, 0, 1, A_ADD, 0, 0, 0);
        row(1, I_BEQ,  1, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 3, A_ADD, 0, 0, 0);
        row(1, I_BEQ,  1, 1,  8, 1, 0, 0, 0, 0, 0, 0, 1, 0, A_SUB, 1, 1, 0);
        row(1, I_BEQ,  0, 1,  0, 1, 0, 1, 0, 0, 0, 0, 0, 1, A_ADD, 0, 0, 0);
        row(1, I_BEQ,  0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 3, A_ADD, 0, 0, 0);
        row(1, I_BEQ,  0, 1,  8, 0, 0, 0, 0, 0, 0, 0, 1, 0, A_SUB, 1, 1, 0);
        // j, jal, jr
        row(1, I_J,    0, 1,  0, 1, 0, 1, 0, 0, 0, 0, 0, 1, A_ADD, 0, 0, 0);
        row(1, I_J,    0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 3, A_ADD, 0, 0, 0);
        row(1, I_J,    0, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, A_ADD, 2, 1, 0);
        row(1, I_JAL,  0, 1,  0, 1, 0, 1, 0, 0, 0, 0, 0, 1, A_ADD, 0, 0, 0);
        row(1, I_JAL,  0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 3, A_ADD, 0, 0, 0);
        row(1, I_JAL,  0, 1, 12, 1, 0, 0, 0, 2, 2, 1, 0, 0, A_ADD, 2, 1, 0);
        row(1, I_JR,   0, 1,  0, 1, 0, 1, 0, 0, 0, 0, 0, 1, A_ADD, 0, 0, 0);
        row(1, I_JR,   0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 3, A_ADD, 0, 0, 0);
        row(1, I_JR,   0, 1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0, A_ADD, 3, 1, 0);
        // unsupported funct: done in EXEC, illegal visible after the edge
        row(1, I_BADF, 0, 1,  0, 1, 0, 1, 0, 0, 0, 0, 0, 1, A_ADD, 0, 0, 0);
        row(1, I_BADF, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 3, A_ADD, 0, 0, 0);
        row(1, I_BADF, 0, 1,  6, 0, 0, 0, 0, 0, 0, 0, 1, 0, A_ADD, 0, 1, 0);
        // following add keeps illegal set
        row(1, I_ADD,  0, 1,  0, 1, 0, 1, 0, 0, 0, 0, 0, 1, A_ADD, 0, 0, 1);
        row(1, I_ADD,  0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 3, A_ADD, 0, 0, 1);
        row(1, I_ADD,  0, 1,  6, 0, 0, 0, 0, 0, 0, 0, 1, 0, A_ADD, 0, 0, 1);
        row(1, I_ADD,  0, 1,  7, 0, 0, 0, 0, 0, 1, 1, 0, 0, A_ADD, 0, 1, 1);
        // sw interrupted by reset in MEMWR: no write, back to FETCH, illegal cleared
        row(1, I_SW,   0, 1,  0, 1, 0, 1, 0, 0, 0, 0, 0, 1, A_ADD, 0, 0, 1);
        row(1, I_SW,   0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 3, A_ADD, 0, 0, 1);
        row(1, I_SW,   0, 1,  2, 0, 0, 0, 0, 0, 0, 0, 1, 2, A_ADD, 0, 0, 1);
        row(1, I_SW,   0, 0,  5, 0, 1, 0, 1, 0, 0, 0, 0, 0, A_ADD, 0, 0, 1);
        row(0, I_SW,   0, 1,  5, 0, 1, 0, 0, 0, 0, 0, 0, 0, A_ADD, 0, 0, 1);
        // unsupported opcode: done in DECODE, illegal after the edge
        row(1, I_BAD,  0, 1,  0, 1, 0, 1, 0, 0, 0, 0, 0, 1, A_ADD, 0, 0, 0);
        row(1, I_BAD,  0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 3, A_ADD, 0, 1, 0);
        row(1, I_ADD,  0, 1,  0, 1, 0, 1, 0, 0, 0, 0, 0, 1, A_ADD, 0, 0, 1);
        row(1, I_ADD,  0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 3, A_ADD, 0, 0, 1);
        row(1, I_ADD,  0, 1,  6, 0, 0, 0, 0, 0, 0, 0, 1, 0, A_ADD, 0, 0, 1);
        row(1, I_ADD,  0, 1,  7, 0, 0, 0, 0, 0, 1, 1, 0, 0, A_ADD, 0, 1, 1);

        // Inputs change on the falling edge; outputs are sampled 2 ns later,
        // well before the next rising edge.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            reset_n   = vecs[i].rst_n;
            instr     = vecs[i].ins;
            zero      = vecs[i].z;
            mem_ready = vecs[i].mr;
            #2;
            checks++;
            if (actual() !== vecs[i].exp) begin
                errors++;
                $display("FAIL row %0d: got state=%0d ctl=%b, required state=%0d ctl=%b",
                         i, actual() >> 21, actual(), vecs[i].exp >> 21, vecs[i].exp);
            end
        end

        // Whole-instruction latencies, including FETCH stalls.
        run_lat(I_LW,   0, 5, "lw");
        run_lat(I_LW,   2, 7, "lw_fetch_stall2");
        run_lat(I_SW,   1, 5, "sw_fetch_stall1");
        run_lat(I_ADD,  0, 4, "add");
        run_lat(I_ADDI, 0, 4, "addi");
        run_lat(I_BEQ,  0, 3, "beq");
        run_lat(I_JAL,  0, 3, "jal");
        run_lat(I_JR,   3, 6, "jr_fetch_stall3");

        // Illegal flag must survive all the legal traffic above.
        @(negedge clock);
        #2;
        checks++;
        if (illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_sticky: got %b, required 1", illegal);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
